fmrv32im_plic_n: RTL and testbench
==================================

Name: fmrv32im_plic_n

Overview:
Parametrised successor to the single-source PLIC in the fmrv32im core. It handles NUM_SRC-1 interrupt sources, each with:
- a programmable priority,
- a per-source enable,
- edge or level gateway mode,
- claim/complete tracking with a global threshold.

It sits on the core's local peripheral register bus (WE/ADDR/WDATA/RDATA plus a new read strobe) and drives EXT_INTERRUPT.

Parameters:
NUM_SRC, 32, number of source slots including reserved ID 0; legal 2..32.
PRIO_W, 3, priority width in bits; priority 0 means never interrupt.
ADDR_W, 6, word-address width of BUS_ADDR.

Ports:
CLK  in  1  clock.
RST  in  1  synchronous active-high reset.
BUS_WE  in  1  register write strobe, one cycle.
BUS_RE  in  1  register read strobe, one cycle; needed for claim side effect.
BUS_ADDR  in  ADDR_W  word address.
BUS_WDATA  in  32  write data.
BUS_RDATA  out  32  read data, registered, valid the cycle after BUS_RE.
INT_IN  in  NUM_SRC  source requests; bit 0 ignored.
INT_OUT  out  1  interrupt to core.

Behaviour:
- Reset values, all applied synchronously on RST: pending, in_service, enable, edge_mask, priority[], threshold, arbiter registers = 0; BUS_RDATA = 0; INT_OUT = 0. RST mid-claim discards in-service state.
- Register map (word address):
  - 0x00 CLAIM/COMPLETE.
  - 0x01 THRESHOLD, PRIO_W bits.
  - 0x02 PENDING, read-only.
  - 0x03 ENABLE.
  - 0x04 EDGE_MASK: 1 = edge, 0 = level.
  - 0x05 IN_SERVICE, read-only.
  - 0x20+i PRIORITY[i].
- Unmapped addresses, i >= NUM_SRC, and bit 0 of every mask: reads return 0, writes are ignored. Upper data bits read 0.
- Gateway, edge mode:
  - prev[i] holds INT_IN[i] registered.
  - A rise (INT_IN & ~prev) sets pending[i], even while in_service[i].
- Gateway, level mode: pending[i] is set when INT_IN[i]=1 and in_service[i]=0.
- Arbiter (sub-module), pass 1 is combinational over eligible = pending & enable & ~in_service with priority > 0.
- Arbiter pass 2 picks the highest priority; ties go to the lowest ID. The result is registered into best_id/best_prio each cycle.
- INT_OUT = (best_prio > threshold), combinational from those registers. Latency from INT_IN rise sampled at edge k: pending set at k, best at k+1, INT_OUT high after k+1.
- Claim: BUS_RE at 0x00 returns claim_id.
  - claim_id = best_id if best_prio > threshold and source best_id is still eligible; otherwise 0.
  - When claim_id != 0 at the end of the cycle: pending[claim_id] <= 0 and in_service[claim_id] <= 1.
  - Back-to-back claims cannot return the same ID; a stale best_id yields 0.
- Complete: BUS_WE at 0x00 with WDATA[4:0] = ID clears in_service[ID]. ID 0, ID >= NUM_SRC, or an ID not in service is ignored.
- Simultaneous events:
  - Gateway set and claim clear on the same source in the same cycle: set wins, so pending stays 1. This only applies in edge mode; a claimed level source is already in service.
  - Complete and claim in the same cycle: impossible on this bus (WE and RE are mutually exclusive); if both are asserted, WE takes precedence and RE returns 0.
- Writes to ENABLE or PRIORITY take effect on the arbiter one cycle later. Pending state is untouched: disabling a source keeps its pending bit.

Decomposition:
- Package fmrv32im_plic_pkg holds:
  - register address localparams (ADDR_CLAIM, ADDR_THRESH, ADDR_PEND, ADDR_EN, ADDR_EDGE, ADDR_INSVC, ADDR_PRIO_BASE);
  - a prio_t typedef parameterised via PRIO_W default;
  - the ID width constant (5).
- One sub-module, fmrv32im_plic_arb: parametrised NUM_SRC/PRIO_W, combinational max tree with lowest-ID tie break, outputs id/prio.

Test Plan:
- Reset then read every register -> all 0, INT_OUT=0; INT_IN=all-ones with nothing enabled -> INT_OUT stays 0.
- Src 3 level, prio 2, thresh 1, enabled; INT_IN[3]=1 -> INT_OUT=1 two edges later. Claim -> RDATA=3, INT_OUT falls. Keep INT_IN[3] high, complete 3 -> re-pends, INT_OUT=1 again.
- Src 5 prio 4 and src 7 prio 4, both pending -> claim returns 5; second claim -> 7; third -> 0. Set thresh=4 with both re-pended -> INT_OUT=0.
- Src 9 edge mode, pulse while in service -> PENDING bit 9 = 1 but INT_OUT=0 until complete 9; then claim returns 9.
- Claim on cycle k and k+1 with only src 2 pending -> returns 2 then 0. Write complete with ID 31 when NUM_SRC=16 -> IN_SERVICE unchanged.
- Assert RST mid-service (in_service=0x8) -> IN_SERVICE=0, INT_OUT=0, RDATA=0 the next cycle.

Source files
------------

// File: rtl/fmrv32im_plic_pkg.sv
// Shared constants and types for the multi-source fmrv32im PLIC.
// Holds the register map, the ID width and the default priority type.
package fmrv32im_plic_pkg;

  localparam int ID_W       = 5;
  localparam int PRIO_W_DEF = 3;

  typedef logic [PRIO_W_DEF-1:0] prio_t;

  localparam int ADDR_CLAIM     = 'h00;
  localparam int ADDR_THRESH    = 'h01;
  localparam int ADDR_PEND      = 'h02;
  localparam int ADDR_EN        = 'h03;
  localparam int ADDR_EDGE      = 'h04;
  localparam int ADDR_INSVC     = 'h05;
  localparam int ADDR_PRIO_BASE = 'h20;

endpackage

// File: rtl/fmrv32im_plic_arb.sv
// Priority arbiter: masks ineligible sources, then picks the highest
// priority with ties resolved toward the lowest source ID.
module fmrv32im_plic_arb
  import fmrv32im_plic_pkg::*;
#(
  parameter int NUM_SRC = 32,
  parameter int PRIO_W  = 3
) (
  input  logic [NUM_SRC-1:0]        eligible_i,
  input  logic [NUM_SRC*PRIO_W-1:0] prio_i,
  output logic [ID_W-1:0]           id_o,
  output logic [PRIO_W-1:0]         prio_o
);

  logic [PRIO_W-1:0] cand [NUM_SRC];
  logic [ID_W-1:0]   best_id;
  logic [PRIO_W-1:0] best_prio;

  // Pass 1: an ineligible source competes with priority 0, which never wins.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      cand[i] = eligible_i[i] ? prio_i[i*PRIO_W +: PRIO_W] : '0;
    end
  end

  // Pass 2: strict greater-than keeps the earliest (lowest) ID on ties.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = 1; i < NUM_SRC; i++) begin
      if (cand[i] > best_prio) begin
        best_id   = ID_W'(i);
        best_prio = cand[i];
      end
    end
  end

  assign id_o   = best_id;
  assign prio_o = best_prio;

  logic unused_slot0;
  assign unused_slot0 = ^{cand[0]};

endmodule

// File: rtl/fmrv32im_plic_n.sv
// Multi-source platform interrupt controller for the fmrv32im core:
// per-source gateway, priority, enable, claim/complete and global threshold.
module fmrv32im_plic_n
  import fmrv32im_plic_pkg::*;
#(
  parameter int NUM_SRC = 32,
  parameter int PRIO_W  = 3,
  parameter int ADDR_W  = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BUS_WE,
  input  logic              BUS_RE,
  input  logic [ADDR_W-1:0] BUS_ADDR,
  input  logic [31:0]       BUS_WDATA,
  output logic [31:0]       BUS_RDATA,
  input  logic [NUM_SRC-1:0] INT_IN,
  output logic              INT_OUT
);

  // Bus: WE and RE are single-cycle strobes with no handshake; a read returns
  // in BUS_RDATA the cycle after RE and holds until the next read.
  // If both strobes arrive together the write wins and the read returns 0.

  localparam logic [NUM_SRC-1:0] SRC_MASK = {{(NUM_SRC-1){1'b1}}, 1'b0};

  logic [NUM_SRC-1:0] pend_q, pend_d, insvc_q, insvc_d;
  logic [NUM_SRC-1:0] en_q, en_d, edge_q, edge_d, prev_q;
  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic [PRIO_W-1:0]  prio_d [NUM_SRC];
  logic [PRIO_W-1:0]  thr_q, thr_d;
  logic [ID_W-1:0]    best_id_q, arb_id;
  logic [PRIO_W-1:0]  best_prio_q, arb_prio;
  logic [31:0]        rdata_q, rdata_d, rd_mux;

  logic [NUM_SRC-1:0]        eligible, gw_set;
  logic [NUM_SRC*PRIO_W-1:0] prio_flat;
  logic [ID_W-1:0]           claim_id;
  logic                      best_ok;

  logic hit_claim, hit_thr, hit_pend, hit_en, hit_edge, hit_insvc;

  assign hit_claim = (BUS_ADDR == ADDR_W'(ADDR_CLAIM));
  assign hit_thr   = (BUS_ADDR == ADDR_W'(ADDR_THRESH));
  assign hit_pend  = (BUS_ADDR == ADDR_W'(ADDR_PEND));
  assign hit_en    = (BUS_ADDR == ADDR_W'(ADDR_EN));
  assign hit_edge  = (BUS_ADDR == ADDR_W'(ADDR_EDGE));
  assign hit_insvc = (BUS_ADDR == ADDR_W'(ADDR_INSVC));

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      prio_flat[i*PRIO_W +: PRIO_W] = prio_q[i];
      eligible[i] = (i != 0) && pend_q[i] && en_q[i] && !insvc_q[i] && (prio_q[i] != '0);
    end
  end

  fmrv32im_plic_arb #(
    .NUM_SRC (NUM_SRC),
    .PRIO_W  (PRIO_W)
  ) u_arb (
    .eligible_i (eligible),
    .prio_i     (prio_flat),
    .id_o       (arb_id),
    .prio_o     (arb_prio)
  );

  assign INT_OUT = (best_prio_q > thr_q);

  // The registered winner can be stale by one cycle, so re-check it is eligible.
  always_comb begin
    best_ok = 1'b0;
    for (int i = 1; i < NUM_SRC; i++) begin
      if (best_id_q == ID_W'(i) && eligible[i]) best_ok = 1'b1;
    end
    claim_id = (best_ok && INT_OUT) ? best_id_q : '0;
  end

  always_comb begin
    rd_mux = '0;
    if (hit_claim)      rd_mux = 32'(claim_id);
    else if (hit_thr)   rd_mux = 32'(thr_q);
    else if (hit_pend)  rd_mux = 32'(pend_q);
    else if (hit_en)    rd_mux = 32'(en_q);
    else if (hit_edge)  rd_mux = 32'(edge_q);
    else if (hit_insvc) rd_mux = 32'(insvc_q);
    for (int i = 1; i < NUM_SRC; i++) begin
      if (BUS_ADDR == ADDR_W'(ADDR_PRIO_BASE + i)) rd_mux = 32'(prio_q[i]);
    end
  end

  always_comb begin
    pend_d  = pend_q;
    insvc_d = insvc_q;
    en_d    = en_q;
    edge_d  = edge_q;
    thr_d   = thr_q;
    prio_d  = prio_q;
    rdata_d = rdata_q;
    if (BUS_WE) begin
      if (BUS_RE) rdata_d = '0;
      for (int i = 1; i < NUM_SRC; i++) begin
        if (hit_claim && BUS_WDATA[ID_W-1:0] == ID_W'(i)) insvc_d[i] = 1'b0;
        if (BUS_ADDR == ADDR_W'(ADDR_PRIO_BASE + i)) prio_d[i] = BUS_WDATA[PRIO_W-1:0];
      end
      if (hit_thr)  thr_d  = BUS_WDATA[PRIO_W-1:0];
      if (hit_en)   en_d   = BUS_WDATA[NUM_SRC-1:0] & SRC_MASK;
      if (hit_edge) edge_d = BUS_WDATA[NUM_SRC-1:0] & SRC_MASK;
    end else if (BUS_RE) begin
      rdata_d = rd_mux;
      for (int i = 1; i < NUM_SRC; i++) begin
        if (hit_claim && claim_id == ID_W'(i)) begin
          pend_d[i]  = 1'b0;
          insvc_d[i] = 1'b1;
        end
      end
    end
    // Level sources look at the post-claim in-service state so a claim sticks;
    // an edge seen on the claim cycle re-pends the source.
    gw_set = ((edge_q & INT_IN & ~prev_q) | (~edge_q & INT_IN & ~insvc_d)) & SRC_MASK;
    pend_d = pend_d | gw_set;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q      <= '0;
      insvc_q     <= '0;
      en_q        <= '0;
      edge_q      <= '0;
      prev_q      <= '0;
      thr_q       <= '0;
      best_id_q   <= '0;
      best_prio_q <= '0;
      rdata_q     <= '0;
      for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
    end else begin
      pend_q      <= pend_d;
      insvc_q     <= insvc_d;
      en_q        <= en_d;
      edge_q      <= edge_d;
      prev_q      <= INT_IN;
      thr_q       <= thr_d;
      best_id_q   <= arb_id;
      best_prio_q <= arb_prio;
      rdata_q     <= rdata_d;
      prio_q      <= prio_d;
    end
  end

  assign BUS_RDATA = rdata_q;

  logic unused_wdata;
  assign unused_wdata = ^BUS_WDATA;

endmodule

// File: tb/tb_fmrv32im_plic_n.sv
// Bench for fmrv32im_plic_n: directed scenarios followed by random bus and
// interrupt traffic, all checked against a cycle-level behavioural model.
module tb_fmrv32im_plic_n;

  localparam int NS = 16;
  localparam int PW = 3;
  localparam int AW = 6;

  logic          CLK = 1'b0;
  logic          RST;
  logic          BUS_WE, BUS_RE;
  logic [AW-1:0] BUS_ADDR;
  logic [31:0]   BUS_WDATA, BUS_RDATA;
  logic [NS-1:0] INT_IN;
  logic          INT_OUT;

  always #5 CLK = ~CLK;

  fmrv32im_plic_n #(.NUM_SRC(NS), .PRIO_W(PW), .ADDR_W(AW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BUS_WE    (BUS_WE),
    .BUS_RE    (BUS_RE),
    .BUS_ADDR  (BUS_ADDR),
    .BUS_WDATA (BUS_WDATA),
    .BUS_RDATA (BUS_RDATA),
    .INT_IN    (INT_IN),
    .INT_OUT   (INT_OUT)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [NS-1:0] m_pend, m_insvc, m_en, m_edge, m_prev;
  int            m_prio [NS];
  int            m_thr, m_best_id, m_best_prio;
  logic [31:0]   m_rdata;
  logic [31:0]   exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit elig(input int i);
    if (i <= 0 || i >= NS) return 1'b0;
    return m_pend[i] && m_en[i] && !m_insvc[i] && (m_prio[i] > 0);
  endfunction

  function automatic logic [31:0] reg_value(input int a, input int claim);
    case (a)
      0: return 32'(claim);
      1: return 32'(m_thr);
      2: return 32'(m_pend);
      3: return 32'(m_en);
      4: return 32'(m_edge);
      5: return 32'(m_insvc);
      default: begin
        if (a > 32 && a < 32 + NS) return 32'(m_prio[a-32]);
        return 32'd0;
      end
    endcase
  endfunction

  // Predict the state after the coming clock edge from the current inputs.
  task automatic model_edge();
    int claim, top, pick, a, id;
    logic [NS-1:0] pend_n, ins_n;
    a = int'(BUS_ADDR);
    if (RST) begin
      m_pend = '0; m_insvc = '0; m_en = '0; m_edge = '0; m_prev = '0;
      m_thr = 0; m_best_id = 0; m_best_prio = 0; m_rdata = '0;
      foreach (m_prio[i]) m_prio[i] = 0;
      return;
    end
    claim = (m_best_prio > m_thr && elig(m_best_id)) ? m_best_id : 0;
    top = 0;
    pick = 0;
    for (int i = 1; i < NS; i++) if (elig(i) && m_prio[i] > top) top = m_prio[i];
    for (int i = NS - 1; i >= 1; i--) if (top > 0 && elig(i) && m_prio[i] == top) pick = i;
    pend_n = m_pend;
    ins_n  = m_insvc;
    if (BUS_WE) begin
      if (BUS_RE) m_rdata = '0;
      id = int'(BUS_WDATA[4:0]);
      if (a == 0 && id > 0 && id < NS) ins_n[id] = 1'b0;
    end else if (BUS_RE) begin
      m_rdata = reg_value(a, claim);
      if (a == 0 && claim != 0) begin
        pend_n[claim] = 1'b0;
        ins_n[claim]  = 1'b1;
      end
    end
    for (int i = 1; i < NS; i++) begin
      if (m_edge[i] ? (INT_IN[i] && !m_prev[i]) : (INT_IN[i] && !ins_n[i])) pend_n[i] = 1'b1;
    end
    if (BUS_WE) begin
      if (a == 1) m_thr = int'(BUS_WDATA[PW-1:0]);
      if (a == 3) begin m_en = BUS_WDATA[NS-1:0]; m_en[0] = 1'b0; end
      if (a == 4) begin m_edge = BUS_WDATA[NS-1:0]; m_edge[0] = 1'b0; end
      if (a > 32 && a < 32 + NS) m_prio[a-32] = int'(BUS_WDATA[PW-1:0]);
    end
    m_pend      = pend_n;
    m_insvc     = ins_n;
    m_prev      = INT_IN;
    m_best_id   = pick;
    m_best_prio = top;
  endtask

  task automatic step();
    model_edge();
    if (BUS_RE) exp_q.push_back(m_rdata);
    @(posedge CLK);
    #1;
    check("int_out", {31'd0, INT_OUT}, (m_best_prio > m_thr) ? 32'd1 : 32'd0);
    if (exp_q.size() > 0) check("rdata", BUS_RDATA, exp_q.pop_front());
    else check("rdata_hold", BUS_RDATA, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic bus(input logic we, input logic re, input int a, input logic [31:0] d);
    BUS_WE = we; BUS_RE = re; BUS_ADDR = AW'(a); BUS_WDATA = d;
    step();
    BUS_WE = 1'b0; BUS_RE = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input int a);
    bus(1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle(2);
    RST = 1'b0;
  endtask

  initial begin
    int k, op, a;
    RST = 1'b1; BUS_WE = 1'b0; BUS_RE = 1'b0; BUS_ADDR = '0; BUS_WDATA = '0; INT_IN = '0;
    do_reset();

    // Reset state of every register
    for (int r = 0; r < 6; r++) begin
      rd(r);
      check("reset_reg", BUS_RDATA, 32'd0);
    end
    rd('h23);
    check("reset_prio3", BUS_RDATA, 32'd0);
    rd('h3f);
    check("unmapped_prio", BUS_RDATA, 32'd0);
    INT_IN = '1;
    idle(3);
    check("none_enabled", {31'd0, INT_OUT}, 32'd0);
    INT_IN = '0;
    do_reset();

    // Level source 3: latency, claim, complete with request still high
    wr('h23, 2); wr(1, 1); wr(3, 32'h8);
    INT_IN[3] = 1'b1;
    step();
    check("lat_edge1", {31'd0, INT_OUT}, 32'd0);
    step();
    check("lat_edge2", {31'd0, INT_OUT}, 32'd1);
    rd(0);
    check("claim3", BUS_RDATA, 32'd3);
    idle(1);
    check("int_fall", {31'd0, INT_OUT}, 32'd0);
    wr(0, 3);
    idle(1);
    check("repend3", {31'd0, INT_OUT}, 32'd1);

    // Tie between 5 and 7 at priority 4
    INT_IN[3] = 1'b0;
    wr(3, 32'hA0); wr('h25, 4); wr('h27, 4);
    INT_IN[5] = 1'b1; INT_IN[7] = 1'b1;
    idle(2);
    rd(0); check("tie_low", BUS_RDATA, 32'd5);
    idle(1);
    rd(0); check("tie_next", BUS_RDATA, 32'd7);
    idle(1);
    rd(0); check("tie_empty", BUS_RDATA, 32'd0);
    wr(1, 4); wr(0, 5); wr(0, 7);
    idle(3);
    check("thresh_eq", {31'd0, INT_OUT}, 32'd0);

    // Edge source 9 pulsed while in service
    wr(1, 0);
    INT_IN = '0;
    wr(3, 32'h200); wr(4, 32'h200); wr('h29, 1);
    INT_IN[9] = 1'b1; step(); INT_IN[9] = 1'b0;
    idle(2);
    rd(0); check("claim9", BUS_RDATA, 32'd9);
    idle(1);
    INT_IN[9] = 1'b1; step(); INT_IN[9] = 1'b0; step();
    rd(2); check("pend9", {31'd0, BUS_RDATA[9]}, 32'd1);
    check("svc_block", {31'd0, INT_OUT}, 32'd0);
    wr(0, 9);
    idle(1);
    check("after_cpl9", {31'd0, INT_OUT}, 32'd1);
    rd(0); check("reclaim9", BUS_RDATA, 32'd9);

    // Back-to-back claims and an out-of-range complete
    wr(3, 32'h4); wr('h22, 1);
    INT_IN[2] = 1'b1;
    idle(2);
    rd(0); check("b2b_first", BUS_RDATA, 32'd2);
    rd(0); check("b2b_second", BUS_RDATA, 32'd0);
    wr(0, 31);
    rd(5); check("cpl_oob", BUS_RDATA, 32'h204);

    // Reset while source 3 is in service
    INT_IN = '0;
    do_reset();
    wr('h23, 2); wr(1, 1); wr(3, 32'h8);
    INT_IN[3] = 1'b1;
    idle(2);
    rd(0); check("claim3_b", BUS_RDATA, 32'd3);
    rd(5); check("insvc_8", BUS_RDATA, 32'h8);
    INT_IN = '0;
    RST = 1'b1; step(); RST = 1'b0;
    check("rst_rdata", BUS_RDATA, 32'd0);
    check("rst_int", {31'd0, INT_OUT}, 32'd0);
    rd(5); check("rst_insvc", BUS_RDATA, 32'd0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(1, NS - 1);
        INT_IN[k] = ~INT_IN[k];
      end
      op = $urandom_range(0, 9);
      case ($urandom_range(0, 4))
        0: a = 1;
        1: a = 3;
        2: a = 4;
        3: a = 32 + $urandom_range(0, 31);
        default: a = $urandom_range(6, 31);
      endcase
      case (op)
        0, 1, 2: rd(0);
        3: rd($urandom_range(0, 5));
        4: wr(0, 32'($urandom_range(0, 31)));
        5: wr(a, $urandom);
        6: bus(1'b1, 1'b1, $urandom_range(0, 1) == 0 ? 0 : a, $urandom);
        default: step();
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
